// File: rtl/adc_stream_packer_if.sv
// rtl/adc_stream_packer_if.sv - FIFO write-port interface for adc_stream_packer
//
// Purpose: groups the external FIFO write handshake.
// Signals:
//   fifo_wr_en  write strobe (driven by the packer)
//   fifo_din    32-bit write data (driven by the packer)
//   fifo_full   FIFO full / backpressure (driven by the FIFO)
// Modports: master = packer side, slave = FIFO side.
interface adc_stream_packer_if;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        fifo_full;

  modport master (output fifo_wr_en, output fifo_din, input fifo_full);
  modport slave  (input fifo_wr_en, input fifo_din, output fifo_full);
endinterface

// File: rtl/adc_stream_packer.sv
// rtl/adc_stream_packer.sv - ADC snapshot, offset correction and FIFO word packer
//
// Purpose: on each accepted ADC sample, snapshots N_CH channels minus per-channel
// offsets (saturated), optionally prepends a timestamp header and writes the packet
// as byte-swapped 32-bit words to an external FIFO with backpressure.
// Ports:
//   trn_clk, pio_reset_n        clock, asynchronous active-low reset
//   stream_on, new_sample       streaming enable (level), sample strobe (pulse)
//   time_counter, adc_chop_dly  header timestamp and chop flag, captured per sample
//   adc_data                    flat channel bus, channel k at [k*ADC_W +: ADC_W]
//   pack_mode, hdr_en           0: two 16-bit channels/word, 1: one channel/word; header enable
//   int_decimate                decimation factor
//   reg_wrt_en/offset/data      offset register write port
//   fifo                        FIFO write port (master modport)
//   overrun, sample_cnt         sticky dropped-sample flag, packets started
module adc_stream_packer #(
  parameter int N_CH  = 32,
  parameter int ADC_W = 18,
  parameter int DEC_W = 16
) (
  input  logic                    trn_clk,
  input  logic                    pio_reset_n,
  input  logic                    stream_on,
  input  logic                    new_sample,
  input  logic [31:0]             time_counter,
  input  logic [N_CH*ADC_W-1:0]   adc_data,
  input  logic                    adc_chop_dly,
  input  logic                    pack_mode,
  input  logic                    hdr_en,
  input  logic [DEC_W-1:0]        int_decimate,
  input  logic                    reg_wrt_en,
  input  logic [15:0]             reg_offset,
  input  logic [31:0]             reg_data,
  adc_stream_packer_if.master     fifo,
  output logic                    overrun,
  output logic [31:0]             sample_cnt
);

  localparam int IW = $clog2(N_CH);
  localparam logic [IW-1:0] LAST0 = IW'(N_CH/2 - 1);
  localparam logic [IW-1:0] LAST1 = IW'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HEADER, S_DATA} state_t;

  state_t             r_state, w_state_nxt;
  logic [ADC_W-1:0]   r_off  [N_CH];
  logic [ADC_W-1:0]   r_snap [N_CH];
  logic               r_stream_d;
  logic [DEC_W-1:0]   r_dec;
  logic [DEC_W-1:0]   r_dec_cnt;
  logic               r_mode;
  logic               r_hdr;
  logic [31:0]        r_time;
  logic               r_chop;
  logic [IW-1:0]      r_ptr;
  logic               r_overrun;
  logic [31:0]        r_sample_cnt;

  logic               w_rise;
  logic               w_pulse;
  logic               w_dec_bypass;
  logic [DEC_W-1:0]   w_dec_base;
  logic [DEC_W-1:0]   w_dec_nxt;
  logic               w_accept;
  logic               w_last;
  logic               w_valid;
  logic               w_write;
  logic [31:0]        w_word;
  logic [31:0]        w_data_word;
  logic [IW-1:0]      w_idx_lo;
  logic [IW-1:0]      w_idx_hi;
  logic               w_unused_ok;

  // Upper reg_data bits are beyond the offset width and intentionally dropped.
  assign w_unused_ok = &{1'b0, reg_data};

  function automatic logic [ADC_W-1:0] sat_sub(input logic [ADC_W-1:0] a,
                                               input logic [ADC_W-1:0] b);
    logic [ADC_W:0] d;
    d = {a[ADC_W-1], a} - {b[ADC_W-1], b};
    // Top two bits disagree -> result left the ADC_W signed range.
    if (d[ADC_W] != d[ADC_W-1])
      sat_sub = d[ADC_W] ? {1'b1, {(ADC_W-1){1'b0}}} : {1'b0, {(ADC_W-1){1'b1}}};
    else
      sat_sub = d[ADC_W-1:0];
  endfunction

  // Stream start and decimation. A rising stream_on restarts the count so the
  // first pulse of a new stream is always accepted.
  assign w_rise       = stream_on & ~r_stream_d;
  assign w_pulse      = stream_on & new_sample;
  assign w_dec_bypass = (r_dec <= DEC_W'(1));
  assign w_dec_base   = w_rise ? '0 : r_dec_cnt;
  assign w_accept     = w_pulse & (w_dec_bypass | (w_dec_base == '0));

  always_comb begin
    w_dec_nxt = w_dec_base;
    if (w_pulse) begin
      if (w_dec_bypass || (w_dec_base == r_dec - DEC_W'(1)))
        w_dec_nxt = '0;
      else
        w_dec_nxt = w_dec_base + DEC_W'(1);
    end
  end

  assign w_last   = r_mode ? (r_ptr == LAST1) : (r_ptr == LAST0);
  assign w_idx_lo = r_ptr << 1;
  assign w_idx_hi = w_idx_lo | IW'(1);

  always_comb begin
    w_data_word = '0;
    if (r_mode) begin
      w_data_word = 32'($signed(r_snap[r_ptr]));
    end else begin
      w_data_word = {r_snap[w_idx_hi][ADC_W-1 -: 16], r_snap[w_idx_lo][ADC_W-1 -: 16]};
      if (w_last)
        w_data_word[16] = r_chop;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid     = 1'b0;
    w_word      = '0;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = r_hdr ? S_HEADER : S_DATA;
      S_HEADER: begin
        w_valid = 1'b1;
        w_word  = r_time;
        if (!fifo.fifo_full) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_valid = 1'b1;
        w_word  = w_data_word;
        if (!fifo.fifo_full && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Dropping stream_on abandons any partial packet.
    if (!stream_on) w_state_nxt = S_IDLE;
  end

  assign w_write         = w_valid & ~fifo.fifo_full;
  assign fifo.fifo_wr_en = w_write;
  assign fifo.fifo_din   = {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]};
  assign overrun         = r_overrun;
  assign sample_cnt      = r_sample_cnt;

  always_ff @(posedge trn_clk or negedge pio_reset_n) begin
    if (!pio_reset_n) begin
      r_state      <= S_IDLE;
      r_stream_d   <= 1'b0;
      r_dec        <= '0;
      r_dec_cnt    <= '0;
      r_mode       <= 1'b0;
      r_hdr        <= 1'b0;
      r_time       <= '0;
      r_chop       <= 1'b0;
      r_ptr        <= '0;
      r_overrun    <= 1'b0;
      r_sample_cnt <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_off[k]  <= '0;
        r_snap[k] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_stream_d <= stream_on;
      r_dec_cnt  <= w_dec_nxt;

      for (int k = 0; k < N_CH; k++) begin
        if (reg_wrt_en && (reg_offset[15:6] == '0) && ({1'b0, reg_offset[5:0]} == 7'(k)))
          r_off[k] <= reg_data[ADC_W-1:0];
      end

      if (r_state == S_IDLE) begin
        r_mode <= pack_mode;
        r_hdr  <= hdr_en;
        r_dec  <= int_decimate;
        if (w_accept) begin
          r_time <= time_counter;
          r_chop <= adc_chop_dly;
        end
      end

      if (r_state == S_CAPTURE) begin
        for (int k = 0; k < N_CH; k++)
          r_snap[k] <= sat_sub(adc_data[k*ADC_W +: ADC_W], r_off[k]);
      end

      if (r_state != S_DATA)
        r_ptr <= '0;
      else if (w_write)
        r_ptr <= r_ptr + IW'(1);

      if (w_rise)
        r_overrun <= 1'b0;
      else if (w_accept && (r_state != S_IDLE))
        r_overrun <= 1'b1;

      if (w_rise)
        r_sample_cnt <= '0;
      else if (r_state == S_CAPTURE)
        r_sample_cnt <= r_sample_cnt + 32'd1;
    end
  end

endmodule
